// File: rtl/rb_pixel_reader.sv
// Row-buffer pixel reader: fetches 32-bit words from a 1-cycle-latency BRAM and streams them out as bytes.
// Optional stall counter output enabled by defining RB_READER_STATS_EN.
module rb_pixel_reader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [8:0]  start_addr,
    input  logic [9:0]  len,
    output logic        r_en,
    output logic [8:0]  r_addr,
    input  logic [31:0] r_data,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_last,
    output logic        busy,
`ifdef RB_READER_STATS_EN
    output logic [15:0] stall_cnt,
`endif
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t      state_q;
    logic        r_en_q, rd_vld_q, busy_q, done_q;
    logic [8:0]  r_addr_q;
    logic [9:0]  req_left_q, words_left_q;
    logic [1:0]  occ_q, bptr_q;
    logic        wptr_q, rptr_q;
    logic [31:0] mem_q [2];

    logic [9:0]  len_sat;
    logic [31:0] head_word;
    logic [7:0]  head_byte;
    logic        xfer, pop, push, last_xfer, issue_d;
    logic [1:0]  occ_d;

    assign len_sat = (len > 10'd512) ? 10'd512 : len;

    // The word landing on r_data this cycle is presented directly when the FIFO is empty,
    // so the first pixel appears without waiting for it to be captured.
    always_comb begin
        head_word = (occ_q != 2'd0) ? mem_q[rptr_q] : r_data;
        case (bptr_q)
            2'd0:    head_byte = head_word[7:0];
            2'd1:    head_byte = head_word[15:8];
            2'd2:    head_byte = head_word[23:16];
            default: head_byte = head_word[31:24];
        endcase
        pix_valid = (state_q == RUN) && ((occ_q != 2'd0) || rd_vld_q);
        pix_data  = pix_valid ? head_byte : 8'd0;
        pix_last  = pix_valid && (bptr_q == 2'd3) && (words_left_q == 10'd1);
        xfer      = pix_valid && pix_ready;
        pop       = xfer && (bptr_q == 2'd3);
        last_xfer = pop && (words_left_q == 10'd1);
        push      = rd_vld_q;
        occ_d     = occ_q + {1'b0, push} - {1'b0, pop};
        issue_d   = (req_left_q != 10'd0) && (({1'b0, occ_d} + {2'b00, r_en_q}) < 3'd2);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            r_en_q       <= 1'b0;
            rd_vld_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            r_addr_q     <= 9'd0;
            req_left_q   <= 10'd0;
            words_left_q <= 10'd0;
            occ_q        <= 2'd0;
            bptr_q       <= 2'd0;
            wptr_q       <= 1'b0;
            rptr_q       <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            rd_vld_q <= r_en_q;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        r_addr_q     <= start_addr;
                        words_left_q <= len_sat;
                        occ_q        <= 2'd0;
                        bptr_q       <= 2'd0;
                        wptr_q       <= 1'b0;
                        rptr_q       <= 1'b0;
                        if (len_sat == 10'd0) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= RUN;
                            busy_q     <= 1'b1;
                            r_en_q     <= 1'b1;
                            req_left_q <= len_sat - 10'd1;
                        end
                    end
                end
                RUN: begin
                    if (r_en_q) r_addr_q <= r_addr_q + 9'd1;
                    occ_q <= occ_d;
                    if (push) wptr_q <= ~wptr_q;
                    if (pop) begin
                        rptr_q       <= ~rptr_q;
                        words_left_q <= words_left_q - 10'd1;
                    end
                    if (xfer) bptr_q <= bptr_q + 2'd1;
                    r_en_q <= issue_d;
                    if (issue_d) req_left_q <= req_left_q - 10'd1;
                    if (last_xfer) begin
                        state_q <= FINISH;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        r_en_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == RUN && push) mem_q[wptr_q] <= r_data;
    end

    assign r_en   = r_en_q;
    assign r_addr = r_addr_q;
    assign busy   = busy_q;
    assign done   = done_q;

`ifdef RB_READER_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= 16'd0;
        end else if (state_q == IDLE && start) begin
            stall_q <= 16'd0;
        end else if (busy_q && pix_ready && !pix_valid && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_rb_pixel_reader.sv
// Bench for rb_pixel_reader: BRAM model plus a byte-address reference for the pixel stream.
// Stall counter checks are compiled in when RB_READER_STATS_EN is defined.
module tb_rb_pixel_reader;

    logic        clk = 1'b0;
    logic        rst_n, start, pix_ready;
    logic [8:0]  start_addr;
    logic [9:0]  len;
    logic        r_en;
    logic [8:0]  r_addr;
    logic [31:0] r_data = 32'd0;
    logic [7:0]  pix_data;
    logic        pix_valid, pix_last, busy, done;
`ifdef RB_READER_STATS_EN
    logic [15:0] stall_cnt;
`endif
    logic [31:0] bram [512];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rb_pixel_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .len(len),
        .r_en(r_en), .r_addr(r_addr), .r_data(r_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last),
        .busy(busy),
`ifdef RB_READER_STATS_EN
        .stall_cnt(stall_cnt),
`endif
        .done(done)
    );

    always @(posedge clk) if (r_en) r_data <= bram[r_addr];

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready always 1, mode 1: ready toggles 1,0,1,..., mode 2: random ready
    task automatic run_burst(input logic [8:0] sa, input int ln, input int mode);
        int lsat, npix, n, issued, cyc_no, last_cyc, done_cyc, budget;
        logic [7:0] prev_data;
        logic prev_last, prev_stall;
        lsat = (ln > 512) ? 512 : ln;
        npix = 4 * lsat;
        start = 1'b1; start_addr = sa; len = ln[9:0]; pix_ready = 1'b1;
        cyc();
        start = 1'b0;
        cyc_no = 1;
        chk("busy_after_start", busy, lsat != 0);
`ifdef RB_READER_STATS_EN
        chk("stall_cleared_on_start", stall_cnt, 16'd0);
`endif
        n = 0; issued = 0; last_cyc = -1; done_cyc = -1;
        prev_stall = 1'b0; prev_data = 8'd0; prev_last = 1'b0;
        budget = 16 * lsat + 20;
        while (done_cyc < 0 && cyc_no < budget) begin
            case (mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = cyc_no[0];
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
            if (prev_stall) begin
                chk("hold_valid", pix_valid, 1'b1);
                chk("hold_data", pix_data, prev_data);
                chk("hold_last", pix_last, prev_last);
            end
            if (r_en) begin
                chk("r_addr", r_addr, (sa + issued) % 512);
                chk("buffer_not_full", (issued - n / 4) < 2, 1'b1);
                issued++;
                chk("reads_within_len", issued <= lsat, 1'b1);
            end
            if (done) begin
                done_cyc = cyc_no;
            end else if (pix_valid && pix_ready) begin
                chk("pix_data", pix_data, (4 * sa + n) % 256);
                chk("pix_last", pix_last, n == npix - 1);
                if (mode == 0) chk("no_gap_cycle", cyc_no, n + 2);
                if (n == npix - 1) last_cyc = cyc_no;
                n++;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_data  = pix_data;
            prev_last  = pix_last;
            cyc();
            cyc_no++;
        end
        chk("done_seen", done_cyc >= 0, 1'b1);
        chk("pix_count", n, npix);
        chk("read_count", issued, lsat);
        if (lsat == 0) chk("done_len0_cycle", done_cyc, 1);
        else           chk("done_after_last", done_cyc, last_cyc + 1);
        chk("done_single_pulse", done, 1'b0);
        chk("busy_after_done", busy, 1'b0);
        chk("r_en_after_done", r_en, 1'b0);
`ifdef RB_READER_STATS_EN
        if (mode == 0) chk("stall_cnt", stall_cnt, (lsat != 0) ? 16'd1 : 16'd0);
`endif
    endtask

    initial begin
        logic [8:0] sa_r;
        int ln_r;
        for (int k = 0; k < 512; k++)
            bram[k] = {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
        rst_n = 1'b0; start = 1'b0; start_addr = 9'd0; len = 10'd0; pix_ready = 1'b1;
        cyc(); cyc();
        chk("rst_r_en", r_en, 1'b0);
        chk("rst_r_addr", r_addr, 9'd0);
        chk("rst_pix_valid", pix_valid, 1'b0);
        chk("rst_pix_data", pix_data, 8'd0);
        chk("rst_pix_last", pix_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
`ifdef RB_READER_STATS_EN
        chk("rst_stall_cnt", stall_cnt, 16'd0);
`endif
        rst_n = 1'b1;
        cyc();

        run_burst(9'd0, 2, 0);
        run_burst(9'd510, 4, 0);
        run_burst(9'd37, 3, 1);
        run_burst(9'd12, 0, 0);
        run_burst(9'd300, 700, 0);

        // abort a len=8 burst after five pixels have been accepted
        start = 1'b1; start_addr = 9'd100; len = 10'd8; pix_ready = 1'b1;
        cyc();
        start = 1'b0;
        repeat (6) cyc();
        rst_n = 1'b0;
        cyc();
        chk("abort_r_en", r_en, 1'b0);
        chk("abort_r_addr", r_addr, 9'd0);
        chk("abort_pix_valid", pix_valid, 1'b0);
        chk("abort_pix_data", pix_data, 8'd0);
        chk("abort_pix_last", pix_last, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("abort_no_done", done, 1'b0);
            chk("abort_no_valid", pix_valid, 1'b0);
        end
        run_burst(9'd200, 8, 0);

        for (int i = 0; i < 6; i++) begin
            sa_r = 9'($urandom_range(0, 511));
            ln_r = int'($urandom_range(1, 24));
            run_burst(sa_r, ln_r, 2);
        end
        run_burst(9'd508, 6, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
